ysyx_22050710_mem_arbiter: RTL and testbench

Two-requester memory arbiter for the ysyx_22050710 NPC core. It shares one downstream memory port between the IFU (instruction fetch, read-only) and the LSU (load/store). It serialises one transaction at a time and routes each response back to the requester that issued it. It sits between the core's IFU/LSU and the memory/bus interface, and replaces their direct private memory access.

---
 rtl/ysyx_22050710_mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_ysyx_22050710_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050710_mem_arbiter.sv
// ysyx_22050710_mem_arbiter
// Shares one downstream memory port between the IFU (read-only fetch) and
// the LSU (load/store). One transaction is in flight at a time. Each
// transaction walks IDLE -> REQ -> RESP, and the response is steered back
// to the requester that owns the transaction.
//
// Arbitration policy is selected by the macro YSYX_22050710_ARB_RR_EN:
//   undefined : fixed priority, LSU wins a tie (the LSU access belongs to
//               the instruction that has already been fetched)
//   defined   : round-robin, a tie goes to the requester that did not own
//               the previous grant; after reset the pointer names the IFU
module ysyx_22050710_mem_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,

  input  logic            i_ifu_req,
  input  logic [AW-1:0]   i_ifu_addr,
  output logic            o_ifu_gnt,
  output logic            o_ifu_rvalid,
  output logic [DW-1:0]   o_ifu_rdata,

  input  logic            i_lsu_req,
  input  logic            i_lsu_we,
  input  logic [AW-1:0]   i_lsu_addr,
  input  logic [DW-1:0]   i_lsu_wdata,
  input  logic [DW/8-1:0] i_lsu_wmask,
  output logic            o_lsu_gnt,
  output logic            o_lsu_rvalid,
  output logic [DW-1:0]   o_lsu_rdata,

  output logic            o_mem_valid,
  output logic            o_mem_we,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [DW/8-1:0] o_mem_wmask,
  input  logic            i_mem_ready,
  input  logic            i_mem_rvalid,
  input  logic [DW-1:0]   i_mem_rdata,

  output logic            o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Owner encoding shared by the owner register and the round-robin pointer.
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wmask_q, wmask_d;

  logic            pick_lsu;
  logic            grant;
  logic            resp_fire;

`ifdef YSYX_22050710_ARB_RR_EN
  logic            last_q, last_d;
`endif

  // Arbitration: decide which requester would win if a grant happens now.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    pick_lsu = 1'b0;
`ifdef YSYX_22050710_ARB_RR_EN
    if (i_ifu_req && i_lsu_req) begin
      pick_lsu = (last_q == OWN_IFU);
    end else begin
      pick_lsu = i_lsu_req;
    end
`else
    pick_lsu = i_lsu_req;
`endif
  end

  // A grant only happens in IDLE; gating with reset keeps the grant pulses
  // low while reset is asserted even if requests are already present.
  assign grant     = (state_q == ST_IDLE) && (i_ifu_req || i_lsu_req) && i_rst;
  assign resp_fire = (state_q == ST_RESP) && i_mem_rvalid;

  assign o_ifu_gnt = grant && !pick_lsu;
  assign o_lsu_gnt = grant &&  pick_lsu;

  // Response steering: only the owner sees rvalid; data is shared.
  assign o_ifu_rvalid = resp_fire && (owner_q == OWN_IFU);
  assign o_lsu_rvalid = resp_fire && (owner_q == OWN_LSU);
  assign o_ifu_rdata  = i_mem_rdata;
  assign o_lsu_rdata  = i_mem_rdata;

  assign o_mem_valid = (state_q == ST_REQ);
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_wmask = wmask_q;
  assign o_busy      = (state_q != ST_IDLE);

  // Next-state logic: walk the transaction and latch the winner's fields.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_REQ;
          owner_d = pick_lsu;
          if (pick_lsu) begin
            we_d    = i_lsu_we;
            addr_d  = i_lsu_addr;
            wdata_d = i_lsu_wdata;
            wmask_d = i_lsu_wmask;
          end else begin
            // Fetches are always reads with no byte enables.
            we_d    = 1'b0;
            addr_d  = i_ifu_addr;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      ST_REQ: begin
        if (i_mem_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_mem_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request registers; reset abandons any transaction in flight.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this clock edge.
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

`ifdef YSYX_22050710_ARB_RR_EN
  // Round-robin pointer: remembers the owner of the most recent grant.
  always_comb begin
    last_d = last_q;
    if (grant) begin
      last_d = pick_lsu;
    end
  end

  // Pointer register; starts at IFU so the first tie goes to the LSU.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      last_q <= OWN_IFU;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050710_mem_arbiter.sv
// Self-checking bench for ysyx_22050710_mem_arbiter.
// The bench plays both requesters and the memory. A small model keeps the
// pending request of each requester and applies the arbitration rule
// (fixed LSU priority, or round-robin under YSYX_22050710_ARB_RR_EN).
module tb_ysyx_22050710_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_ifu_req;
  logic [AW-1:0]   i_ifu_addr;
  logic            o_ifu_gnt;
  logic            o_ifu_rvalid;
  logic [DW-1:0]   o_ifu_rdata;
  logic            i_lsu_req;
  logic            i_lsu_we;
  logic [AW-1:0]   i_lsu_addr;
  logic [DW-1:0]   i_lsu_wdata;
  logic [DW/8-1:0] i_lsu_wmask;
  logic            o_lsu_gnt;
  logic            o_lsu_rvalid;
  logic [DW-1:0]   o_lsu_rdata;
  logic            o_mem_valid;
  logic            o_mem_we;
  logic [AW-1:0]   o_mem_addr;
  logic [DW-1:0]   o_mem_wdata;
  logic [DW/8-1:0] o_mem_wmask;
  logic            i_mem_ready;
  logic            i_mem_rvalid;
  logic [DW-1:0]   i_mem_rdata;
  logic            o_busy;

  ysyx_22050710_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ifu_req    (i_ifu_req),
    .i_ifu_addr   (i_ifu_addr),
    .o_ifu_gnt    (o_ifu_gnt),
    .o_ifu_rvalid (o_ifu_rvalid),
    .o_ifu_rdata  (o_ifu_rdata),
    .i_lsu_req    (i_lsu_req),
    .i_lsu_we     (i_lsu_we),
    .i_lsu_addr   (i_lsu_addr),
    .i_lsu_wdata  (i_lsu_wdata),
    .i_lsu_wmask  (i_lsu_wmask),
    .o_lsu_gnt    (o_lsu_gnt),
    .o_lsu_rvalid (o_lsu_rvalid),
    .o_lsu_rdata  (o_lsu_rdata),
    .o_mem_valid  (o_mem_valid),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_wmask  (o_mem_wmask),
    .i_mem_ready  (i_mem_ready),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  always @(posedge i_clk) cyc++;

  // Model: pending requests and the last owner (1 = LSU).
  logic        ifu_pend = 1'b0;
  logic [63:0] ifu_a    = '0;
  logic        lsu_pend = 1'b0;
  logic        lsu_we   = 1'b0;
  logic [63:0] lsu_a    = '0;
  logic [63:0] lsu_wd   = '0;
  logic [7:0]  lsu_wm   = '0;
  logic        last_lsu = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Who should win given the pending requests and the policy.
  function automatic logic model_pick_lsu();
    if (ifu_pend && lsu_pend) begin
`ifdef YSYX_22050710_ARB_RR_EN
      return !last_lsu;
`else
      return 1'b1;
`endif
    end
    return lsu_pend;
  endfunction

  task automatic drive_reqs();
    i_ifu_req   = ifu_pend;
    i_ifu_addr  = ifu_a;
    i_lsu_req   = lsu_pend;
    i_lsu_we    = lsu_we;
    i_lsu_addr  = lsu_a;
    i_lsu_wdata = lsu_wd;
    i_lsu_wmask = lsu_wm;
  endtask

  // After its grant the winner may change its fields freely.
  task automatic scramble(input logic wl);
    if (wl) begin
      i_lsu_we    = 1'($urandom);
      i_lsu_addr  = {$urandom, $urandom};
      i_lsu_wdata = {$urandom, $urandom};
      i_lsu_wmask = 8'($urandom);
    end else begin
      i_ifu_addr  = {$urandom, $urandom};
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ifu_gnt"},    o_ifu_gnt,    0);
    check({tag, "_lsu_gnt"},    o_lsu_gnt,    0);
    check({tag, "_ifu_rvalid"}, o_ifu_rvalid, 0);
    check({tag, "_lsu_rvalid"}, o_lsu_rvalid, 0);
    check({tag, "_mem_valid"},  o_mem_valid,  0);
    check({tag, "_busy"},       o_busy,       0);
    check({tag, "_mem_we"},     o_mem_we,     0);
    check({tag, "_mem_addr"},   o_mem_addr,   0);
    check({tag, "_mem_wdata"},  o_mem_wdata,  0);
    check({tag, "_mem_wmask"},  o_mem_wmask,  0);
  endtask

  // One full transaction from IDLE: grant cycle, rw+1 REQ cycles, rv+1 RESP
  // cycles. Each cycle starts at a falling edge; outputs are sampled 1 ns later.
  task automatic do_txn(input int rw, input int rv, input logic [63:0] rdat,
                        output logic obs_lsu_gnt, output int gcyc);
    logic        wl;
    logic        ewe;
    logic [63:0] ea, ed;
    logic [7:0]  em;
    wl = model_pick_lsu();
    @(negedge i_clk);
    drive_reqs();
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'($urandom);
    #1;
    check("idle_busy",      o_busy,       0);
    check("idle_mem_valid", o_mem_valid,  0);
    check("ifu_gnt",        o_ifu_gnt,    !wl);
    check("lsu_gnt",        o_lsu_gnt,    wl);
    check("idle_ifu_rv",    o_ifu_rvalid, 0);
    check("idle_lsu_rv",    o_lsu_rvalid, 0);
    obs_lsu_gnt = o_lsu_gnt;
    gcyc = cyc;
    if (wl) begin
      ewe = lsu_we; ea = lsu_a; ed = lsu_wd; em = lsu_wm;
      lsu_pend = 1'b0;
    end else begin
      ewe = 1'b0; ea = ifu_a; ed = '0; em = '0;
      ifu_pend = 1'b0;
    end
    last_lsu = wl;
    for (int w = 0; w <= rw; w++) begin
      @(negedge i_clk);
      drive_reqs();
      scramble(wl);
      i_mem_ready  = (w == rw);
      i_mem_rvalid = (w == rw) ? 1'b0 : 1'($urandom);
      #1;
      check("req_mem_valid", o_mem_valid,  1);
      check("req_busy",      o_busy,       1);
      check("req_we",        o_mem_we,     ewe);
      check("req_addr",      o_mem_addr,   ea);
      check("req_wmask",     o_mem_wmask,  em);
      if (wl) check("req_wdata", o_mem_wdata, ed);
      check("req_ifu_gnt",   o_ifu_gnt,    0);
      check("req_lsu_gnt",   o_lsu_gnt,    0);
      check("req_ifu_rv",    o_ifu_rvalid, 0);
      check("req_lsu_rv",    o_lsu_rvalid, 0);
    end
    for (int w = 0; w <= rv; w++) begin
      @(negedge i_clk);
      drive_reqs();
      scramble(wl);
      i_mem_ready  = 1'b0;
      i_mem_rvalid = (w == rv);
      i_mem_rdata  = (w == rv) ? rdat : {$urandom, $urandom};
      #1;
      check("resp_mem_valid", o_mem_valid,  0);
      check("resp_busy",      o_busy,       1);
      check("resp_ifu_gnt",   o_ifu_gnt,    0);
      check("resp_lsu_gnt",   o_lsu_gnt,    0);
      check("resp_ifu_rv",    o_ifu_rvalid, (w == rv) && !wl);
      check("resp_lsu_rv",    o_lsu_rvalid, (w == rv) && wl);
      if (w == rv) begin
        if (wl) check("lsu_rdata", o_lsu_rdata, rdat);
        else    check("ifu_rdata", o_ifu_rdata, rdat);
      end
    end
  endtask

  task automatic drain();
    logic g;
    int   c;
    for (int k = 0; k < 4 && (ifu_pend || lsu_pend); k++) begin
      do_txn(0, 0, {$urandom, $urandom}, g, c);
    end
  endtask

  initial begin
    logic g;
    int   c, c_prev;
    logic exp_l;

    // Reset with both requests and a memory response present.
    i_rst = 1'b0;
    i_ifu_req = 1'b1; i_ifu_addr = 64'h8000_0000;
    i_lsu_req = 1'b1; i_lsu_we = 1'b1; i_lsu_addr = 64'h10;
    i_lsu_wdata = '1; i_lsu_wmask = '1;
    i_mem_ready = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = '0;
    #1;
    check_outputs_zero("reset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    ifu_pend = 1'b0; lsu_pend = 1'b0; last_lsu = 1'b0;
    drive_reqs();
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;

    // Single IFU read, zero-wait memory.
    ifu_pend = 1'b1; ifu_a = 64'h8000_0000;
    do_txn(0, 0, 64'h0000_0413_0010_0073, g, c);

    // Both requesters held high for four transactions.
    for (int k = 0; k < 4; k++) begin
      if (!ifu_pend) begin ifu_pend = 1'b1; ifu_a = {$urandom, $urandom}; end
      if (!lsu_pend) begin
        lsu_pend = 1'b1; lsu_we = 1'($urandom); lsu_a = {$urandom, $urandom};
        lsu_wd = {$urandom, $urandom}; lsu_wm = 8'($urandom);
      end
`ifdef YSYX_22050710_ARB_RR_EN
      exp_l = (k % 2 == 0);
`else
      exp_l = 1'b1;
`endif
      do_txn($urandom_range(0, 1), $urandom_range(0, 1), {$urandom, $urandom}, g, c);
      check("tie_order", g, exp_l);
    end
    drain();

    // LSU write with ready and rvalid stalls.
    lsu_pend = 1'b1; lsu_we = 1'b1; lsu_a = 64'h8000_1008;
    lsu_wd = 64'hDEAD_BEEF; lsu_wm = 8'h0F;
    do_txn(3, 2, {$urandom, $urandom}, g, c);

    // Stray memory response while idle.
    @(negedge i_clk);
    drive_reqs();
    i_mem_rvalid = 1'b1;
    #1;
    check("stray_ifu_rv", o_ifu_rvalid, 0);
    check("stray_lsu_rv", o_lsu_rvalid, 0);
    check("stray_busy",   o_busy,       0);
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    #1;
    check("stray_busy_after", o_busy,      0);
    check("stray_mem_valid",  o_mem_valid, 0);

    // Reset while waiting in RESP.
    @(negedge i_clk);
    i_ifu_req = 1'b1; i_ifu_addr = 64'h8000_0040;
    #1;
    check("rst_txn_gnt", o_ifu_gnt, 1);
    @(negedge i_clk);
    i_ifu_req = 1'b0; i_mem_ready = 1'b1;
    #1;
    check("rst_txn_req", o_mem_valid, 1);
    @(negedge i_clk);
    i_mem_ready = 1'b0;
    #1;
    check("rst_txn_resp_busy", o_busy, 1);
    #2;
    i_rst = 1'b0;
    i_ifu_req = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    @(negedge i_clk);
    i_rst = 1'b1;
    i_ifu_req = 1'b0;
    i_mem_rvalid = 1'b1;
    last_lsu = 1'b0;
    #1;
    check("post_rst_ifu_rv", o_ifu_rvalid, 0);
    check("post_rst_lsu_rv", o_lsu_rvalid, 0);
    check("post_rst_busy",   o_busy,       0);
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    ifu_pend = 1'b1; ifu_a = 64'h8000_0080;
    do_txn(0, 1, {$urandom, $urandom}, g, c);

    // Back-to-back IFU reads: grants exactly three cycles apart.
    c_prev = 0;
    for (int k = 0; k < 4; k++) begin
      ifu_pend = 1'b1; ifu_a = 64'h8000_0000 + 64'(4 * k);
      do_txn(0, 0, {$urandom, $urandom}, g, c);
      if (k > 0) check("b2b_spacing", 64'(c - c_prev), 3);
      c_prev = c;
    end

    // Randomised mix of requests and memory stalls.
    for (int k = 0; k < 24; k++) begin
      if (!ifu_pend && $urandom_range(0, 1) == 1) begin
        ifu_pend = 1'b1; ifu_a = {$urandom, $urandom};
      end
      if (!lsu_pend && $urandom_range(0, 1) == 1) begin
        lsu_pend = 1'b1; lsu_we = 1'($urandom); lsu_a = {$urandom, $urandom};
        lsu_wd = {$urandom, $urandom}; lsu_wm = 8'($urandom);
      end
      if (!ifu_pend && !lsu_pend) begin
        ifu_pend = 1'b1; ifu_a = {$urandom, $urandom};
      end
      do_txn($urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom}, g, c);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Guard against a run that never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
